// File: rtl/pc_sequencer_pkg.sv
// Shared types and defaults for the program-counter sequencer slice.
package pc_seq_pkg;

  localparam int PC_W_DEF        = 6;
  localparam int STACK_DEPTH_DEF = 4;
  localparam int RESET_VEC_DEF   = 0;

  typedef enum logic [1:0] {BOOT, RUN, HALT, FAULT} seq_state_t;

  typedef enum logic [2:0] {HOLD, INC, BRANCH, JUMP, CALL, RET, VEC} pc_sel_t;

  // Occupancy counter must reach DEPTH itself, hence the extra bit.
  function automatic int sp_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between decode/branch logic and the PC sequencer.
interface pc_sequencer_if
  import pc_seq_pkg::*;
#(
  parameter int PC_W        = PC_W_DEF,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF
);
  localparam int SP_W = sp_width(STACK_DEPTH);

  logic [PC_W-1:0] pc_cur;
  logic [PC_W-1:0] pc_next;
  logic            stall;
  logic            branch_taken;
  logic [PC_W-1:0] branch_off;
  logic            jump;
  logic            call;
  logic [PC_W-1:0] target;
  logic            ret;
  logic            halt;
  logic            resume;
  logic            fetch_valid;
  logic            halted;
  logic            fault;
  logic [SP_W-1:0] sp;

  modport master (
    output pc_cur, stall, branch_taken, branch_off, jump, call, target,
           ret, halt, resume,
    input  pc_next, fetch_valid, halted, fault, sp
  );

  modport slave (
    input  pc_cur, stall, branch_taken, branch_off, jump, call, target,
           ret, halt, resume,
    output pc_next, fetch_valid, halted, fault, sp
  );

endinterface

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO; push/pop are trusted, the caller guards full/empty.
module ret_stack #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4,
  parameter int SP_W  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [SP_W-1:0]  sp,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;

  assign wr_idx  = AW'(sp);
  assign top_idx = AW'(sp - SP_W'(1));
  assign top     = mem[top_idx];
  assign full    = (sp == SP_W'(DEPTH));
  assign empty   = (sp == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= '0;
    end else if (push) begin
      mem[wr_idx] <= din;
      sp          <= sp + SP_W'(1);
    end else if (pop) begin
      sp <= sp - SP_W'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC selection with boot/run/halt/fault sequencing and a call/return stack.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int PC_W        = PC_W_DEF,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF,
  parameter int RESET_VEC   = RESET_VEC_DEF
) (
  input  logic          clk,
  input  logic          rst,
  pc_sequencer_if.slave bus
);
  localparam int SP_W = sp_width(STACK_DEPTH);

  seq_state_t      state, state_nx;
  pc_sel_t         sel;
  logic            push, pop, fault_set, fault_q;
  logic            stk_full, stk_empty;
  logic [PC_W-1:0] stk_top, inc_pc;
  logic [SP_W-1:0] stk_sp;

  assign inc_pc = bus.pc_cur + PC_W'(1);

  ret_stack #(
    .WIDTH (PC_W),
    .DEPTH (STACK_DEPTH),
    .SP_W  (SP_W)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (inc_pc),
    .top   (stk_top),
    .sp    (stk_sp),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // Reset is folded into the select so pc_next shows RESET_VEC in the reset cycle.
  always_comb begin
    sel       = HOLD;
    push      = 1'b0;
    pop       = 1'b0;
    fault_set = 1'b0;
    state_nx  = state;
    if (rst) begin
      sel = VEC;
    end else begin
      unique case (state)
        BOOT: begin
          sel      = VEC;
          state_nx = RUN;
        end
        RUN: begin
          if (bus.halt) begin
            state_nx = HALT;
          end else if (bus.stall) begin
            sel = HOLD;
          end else if (bus.ret) begin
            if (stk_empty) begin
              fault_set = 1'b1;
              state_nx  = FAULT;
            end else begin
              sel = RET;
              pop = 1'b1;
            end
          end else if (bus.call) begin
            if (stk_full) begin
              fault_set = 1'b1;
              state_nx  = FAULT;
            end else begin
              sel  = CALL;
              push = 1'b1;
            end
          end else if (bus.jump) begin
            sel = JUMP;
          end else if (bus.branch_taken) begin
            sel = BRANCH;
          end else begin
            sel = INC;
          end
        end
        HALT: begin
          if (bus.resume && !bus.halt) state_nx = RUN;
        end
        FAULT: begin
          state_nx = FAULT;
        end
        default: state_nx = BOOT;
      endcase
    end
  end

  // Same-width add wraps modulo 2^PC_W, which is exactly a sign-extended offset.
  always_comb begin
    unique case (sel)
      INC:         bus.pc_next = inc_pc;
      BRANCH:      bus.pc_next = bus.pc_cur + bus.branch_off;
      JUMP, CALL:  bus.pc_next = bus.target;
      RET:         bus.pc_next = stk_top;
      VEC:         bus.pc_next = PC_W'(RESET_VEC);
      default:     bus.pc_next = bus.pc_cur;
    endcase
  end

  assign bus.fetch_valid = !rst && (state == RUN);
  assign bus.halted      = !rst && (state == HALT);
  assign bus.fault       = fault_q;
  assign bus.sp          = stk_sp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= BOOT;
      fault_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (fault_set) fault_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vectors, multi-cycle sequences and random traffic vs a queue model.
module tb_pc_sequencer;

  localparam int PC_W  = 6;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_sequencer_if #(.PC_W(PC_W), .STACK_DEPTH(DEPTH)) bus ();

  pc_sequencer #(
    .PC_W        (PC_W),
    .STACK_DEPTH (DEPTH),
    .RESET_VEC   (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // PC register emulation: either follow pc_next or force an arbitrary pc_cur.
  logic            pc_follow = 1'b0;
  logic [PC_W-1:0] pc_force  = '0;
  logic [PC_W-1:0] pc_reg    = '0;
  always @(posedge clk) pc_reg <= bus.pc_next;
  assign bus.pc_cur = pc_follow ? pc_reg : pc_force;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Behavioural model: mode flags plus a queue standing in for the return stack.
  bit          m_boot, m_halt, m_fault, m_flag;
  int unsigned m_stack[$];
  logic [PC_W-1:0] e_pc;
  logic        e_fv, e_hl, e_ft;
  int unsigned e_sp;

  task automatic model(input bit commit);
    int pc;
    int off;
    pc    = int'(bus.pc_cur);
    off   = (bus.branch_off >= 6'd32) ? int'(bus.branch_off) - 64 : int'(bus.branch_off);
    e_sp  = m_stack.size();
    e_ft  = m_flag;
    e_fv  = 1'b0;
    e_hl  = 1'b0;
    e_pc  = bus.pc_cur;
    if (rst) begin
      e_pc = '0;
      if (commit) begin
        m_boot = 1; m_halt = 0; m_fault = 0; m_flag = 0;
        m_stack.delete();
      end
    end else if (m_boot) begin
      e_pc = '0;
      if (commit) m_boot = 0;
    end else if (m_fault) begin
      e_pc = bus.pc_cur;
    end else if (m_halt) begin
      e_hl = 1'b1;
      if (commit && bus.resume && !bus.halt) m_halt = 0;
    end else begin
      e_fv = 1'b1;
      if (bus.halt) begin
        if (commit) m_halt = 1;
      end else if (bus.stall) begin
        e_pc = bus.pc_cur;
      end else if (bus.ret) begin
        if (m_stack.size() == 0) begin
          if (commit) begin m_fault = 1; m_flag = 1; end
        end else begin
          e_pc = PC_W'(m_stack[$]);
          if (commit) void'(m_stack.pop_back());
        end
      end else if (bus.call) begin
        if (m_stack.size() == DEPTH) begin
          if (commit) begin m_fault = 1; m_flag = 1; end
        end else begin
          e_pc = bus.target;
          if (commit) m_stack.push_back((pc + 1) % 64);
        end
      end else if (bus.jump) begin
        e_pc = bus.target;
      end else if (bus.branch_taken) begin
        e_pc = PC_W'((pc + off + 64) % 64);
      end else begin
        e_pc = PC_W'((pc + 1) % 64);
      end
    end
  endtask

  // Inputs are set just after a rising edge; checks happen at the falling edge.
  task automatic cyc(input string tag, input int exp_pc);
    #4;
    model(1'b0);
    if (exp_pc >= 0) check({tag, " pc_next(const)"}, 32'(bus.pc_next), 32'(exp_pc));
    check({tag, " pc_next"}, 32'(bus.pc_next), 32'(e_pc));
    check({tag, " fetch_valid"}, 32'(bus.fetch_valid), 32'(e_fv));
    check({tag, " halted"}, 32'(bus.halted), 32'(e_hl));
    check({tag, " fault"}, 32'(bus.fault), 32'(e_ft));
    check({tag, " sp"}, 32'(bus.sp), 32'(e_sp));
    model(1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stall = 0; bus.branch_taken = 0; bus.branch_off = '0; bus.jump = 0;
    bus.call = 0; bus.target = '0; bus.ret = 0; bus.halt = 0; bus.resume = 0;
  endtask

  task automatic setpc(input int v);
    pc_follow = 1'b0;
    pc_force  = PC_W'(v);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cyc("rst", 0);
    rst = 1'b0;
    cyc("boot", 0);
  endtask

  typedef struct {
    string           name;
    logic [PC_W-1:0] pc;
    logic            stall;
    logic            br;
    logic [PC_W-1:0] off;
    logic            jump;
    logic [PC_W-1:0] tgt;
    int              exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{"wrap",        6'd63, 1'b0, 1'b0, 6'd0,       1'b0, 6'd0,  0};
    vecs[1] = '{"br_neg",      6'd2,  1'b0, 1'b1, 6'b111101,  1'b0, 6'd0,  63};
    vecs[2] = '{"br_pos",      6'd10, 1'b0, 1'b1, 6'd5,       1'b0, 6'd0,  15};
    vecs[3] = '{"stall_jump",  6'd7,  1'b1, 1'b0, 6'd0,       1'b1, 6'd30, 7};
    vecs[4] = '{"jump",        6'd20, 1'b0, 1'b0, 6'd0,       1'b1, 6'd45, 45};
    vecs[5] = '{"br_min",      6'd0,  1'b0, 1'b1, 6'b100000,  1'b0, 6'd0,  32};
    vecs[6] = '{"jump_over_br",6'd5,  1'b0, 1'b1, 6'd3,       1'b1, 6'd9,  9};
    vecs[7] = '{"br_zero",     6'd33, 1'b0, 1'b1, 6'd0,       1'b0, 6'd0,  33};

    idle();
    rst = 1'b1;
    pc_follow = 1'b1;
    @(posedge clk);
    #1;

    // Reset held two cycles, BOOT, then sequential fetch from 0.
    cyc("rst0", 0);
    cyc("rst1", 0);
    rst = 1'b0;
    cyc("boot", 0);
    for (int i = 0; i < 4; i++) begin
      check("seq pc_cur", 32'(bus.pc_cur), 32'(i));
      cyc("seq", i + 1);
    end

    // Single-cycle RUN vectors with forced pc_cur.
    foreach (vecs[i]) begin
      idle();
      setpc(int'(vecs[i].pc));
      bus.stall        = vecs[i].stall;
      bus.branch_taken = vecs[i].br;
      bus.branch_off   = vecs[i].off;
      bus.jump         = vecs[i].jump;
      bus.target       = vecs[i].tgt;
      cyc(vecs[i].name, vecs[i].exp);
    end

    // Nested calls and returns.
    idle(); setpc(5);  bus.call = 1; bus.target = 6'd20; cyc("call1", 20);
    idle(); setpc(21); bus.call = 1; bus.target = 6'd40; cyc("call2", 40);
    idle(); setpc(41); bus.call = 1; bus.target = 6'd50; cyc("call3", 50);
    check("nest sp", 32'(bus.sp), 32'd3);
    idle(); setpc(50); bus.ret = 1; cyc("ret1", 42);
    idle(); setpc(42); bus.ret = 1; cyc("ret2", 22);
    idle(); setpc(22); bus.ret = 1; cyc("ret3", 6);
    check("nest sp end", 32'(bus.sp), 32'd0);
    check("nest fault", 32'(bus.fault), 32'd0);

    // ret+call together: pop only.
    idle(); setpc(10); bus.call = 1; bus.target = 6'd30; cyc("rc_call", 30);
    idle(); setpc(30); bus.call = 1; bus.ret = 1; bus.target = 6'd55; cyc("rc_both", 11);
    check("rc sp", 32'(bus.sp), 32'd0);

    // Push of 63+1 wraps to 0.
    idle(); setpc(63); bus.call = 1; bus.target = 6'd1; cyc("call63", 1);
    idle(); setpc(1);  bus.ret = 1; cyc("ret63", 0);

    // halt+call: HALT without a push, then resume.
    idle(); setpc(12); bus.halt = 1; bus.call = 1; bus.target = 6'd50; cyc("halt", 12);
    idle();
    for (int i = 0; i < 5; i++) begin
      check("halted", 32'(bus.halted), 32'd1);
      cyc("halt_hold", 12);
    end
    bus.halt = 1; bus.resume = 1; cyc("halt_res_both", 12);
    idle(); bus.resume = 1; cyc("resume", 12);
    idle(); cyc("after_resume", 13);
    check("halt sp", 32'(bus.sp), 32'd0);

    // Overflow on the fifth call, FAULT ignores resume.
    for (int k = 0; k < DEPTH; k++) begin
      idle(); setpc(k * 10); bus.call = 1; bus.target = PC_W'(k * 10 + 5);
      cyc("fill", k * 10 + 5);
    end
    idle(); setpc(40); bus.call = 1; bus.target = 6'd60; cyc("overflow", 40);
    check("ovf fault", 32'(bus.fault), 32'd1);
    for (int i = 0; i < 3; i++) begin
      idle(); bus.resume = 1; bus.jump = 1; bus.target = 6'd9;
      cyc("fault_hold", 40);
    end
    do_reset();
    check("rst clears fault", 32'(bus.fault), 32'd0);

    // Underflow.
    idle(); setpc(3); bus.ret = 1; cyc("underflow", 3);
    check("udf fault", 32'(bus.fault), 32'd1);
    do_reset();

    // Reset mid-run with sp=2.
    idle(); setpc(5);  bus.call = 1; bus.target = 6'd20; cyc("mr_call1", 20);
    idle(); setpc(20); bus.call = 1; bus.target = 6'd30; cyc("mr_call2", 30);
    check("mr sp2", 32'(bus.sp), 32'd2);
    idle(); rst = 1'b1; cyc("mr_rst", 0);
    check("mr sp0", 32'(bus.sp), 32'd0);
    rst = 1'b0; pc_follow = 1'b1; cyc("mr_boot", 0);
    check("mr first fetch", 32'(bus.pc_cur), 32'd0);
    cyc("mr_run", 1);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst              = ($urandom_range(0, 59) == 0);
      bus.stall        = ($urandom_range(0, 9) == 0);
      bus.branch_taken = ($urandom_range(0, 3) == 0);
      bus.branch_off   = PC_W'($urandom);
      bus.jump         = ($urandom_range(0, 5) == 0);
      bus.call         = ($urandom_range(0, 6) == 0);
      bus.ret          = ($urandom_range(0, 6) == 0);
      bus.target       = PC_W'($urandom);
      bus.halt         = ($urandom_range(0, 24) == 0);
      bus.resume       = ($urandom_range(0, 2) == 0);
      pc_follow        = ($urandom_range(0, 4) != 0);
      pc_force         = PC_W'($urandom);
      cyc("rand", -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-address controller for the 6-bit program counter register. Each cycle it selects the value presented on the register's `pc_in`: sequential increment, relative branch, absolute jump, call/return via a small return-address stack, or hold for stall/halt. It sits between the decode/branch logic and the PC register, and sequences boot, run, halt and fault conditions for instruction fetch.

## Interface
- `PC_W`, default 6: PC width; all address arithmetic is modulo 2^PC_W.
- `STACK_DEPTH`, default 4: number of return-address stack entries.
- `RESET_VEC`, default 0: first fetch address after reset.
- Reset `rst` is synchronous and active-high; the clock is `clk`.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `pc_cur`  in  PC_W  current PC, taken from the PC register output.
- `pc_next`  out  PC_W  next PC, driving the PC register input.
- `stall`  in  1  freeze the PC this cycle.
- `branch_taken`  in  1  relative branch request.
- `branch_off`  in  PC_W  signed two's-complement offset.
- `jump`  in  1  absolute jump request.
- `call`  in  1  push the return address and jump.
- `target`  in  PC_W  absolute target for `jump` and `call`.
- `ret`  in  1  pop the return address.
- `halt`  in  1  enter HALT.
- `resume`  in  1  leave HALT.
- `fetch_valid`  out  1  `pc_cur` is a valid fetch address this cycle.
- `halted`  out  1  the state is HALT.
- `fault`  out  1  sticky flag: stack overflow or underflow occurred.
- `sp`  out  log2(STACK_DEPTH)+1  stack occupancy, from 0 to STACK_DEPTH.

## Operation
- **States:** BOOT, RUN, HALT, FAULT.
- **Reset:** state=BOOT, sp=0, fault=0.
  - While `rst` is high: `pc_next`=RESET_VEC, `fetch_valid`=0, `halted`=0.
- **BOOT:** `pc_next`=RESET_VEC, `fetch_valid`=0; unconditionally go to RUN next cycle.
- **RUN:** `fetch_valid`=1. The first matching rule below applies:
  1. `halt`: `pc_next`=`pc_cur`, go to HALT.
  2. `stall`: `pc_next`=`pc_cur`; all other controls are ignored; the stack is unchanged.
  3. `ret`:
     - sp=0 is underflow: `pc_next`=`pc_cur`, fault=1, go to FAULT.
     - Otherwise: `pc_next`=top entry, sp−1.
  4. `call`:
     - sp=STACK_DEPTH is overflow: no push, `pc_next`=`pc_cur`, fault=1, go to FAULT.
     - Otherwise: push `pc_cur`+1, `pc_next`=`target`, sp+1.
  5. `jump`: `pc_next`=`target`.
  6. `branch_taken`: `pc_next`=`pc_cur`+sext(`branch_off`). The offset is relative to `pc_cur`, not `pc_cur`+1.
  7. Otherwise: `pc_next`=`pc_cur`+1.
- **Arithmetic:** all sums are truncated to PC_W bits.
  - 63+1 → 0.
  - 2+(−3 = 6'b111101) → 63.
  - Pushed return address 63+1 → 0.
- **HALT:** `pc_next`=`pc_cur`, `fetch_valid`=0, `halted`=1.
  - `resume` (and `halt` not asserted): go to RUN next cycle; `pc_next` is still `pc_cur` on that cycle.
  - All other controls are ignored.
- **FAULT:** `pc_next`=`pc_cur`, `fetch_valid`=0. Only `rst` exits this state.
- `call` and `ret` asserted together: `ret` wins and `call` is dropped.

## Timing
- `pc_next` and `fetch_valid` are combinational from state, sp, the stack top and the inputs. There is no registered output path.
- Redirect latency is 1 cycle: `pc_next` is captured by the PC register at the edge, and the new `pc_cur` is visible the following cycle.
- State, sp, stack entries and fault update on the rising `clk` edge.
- A push or pop is visible to a `ret` issued in the next cycle; back-to-back call/ret is legal.
- Reset mid-operation (any state, any sp):
  - Next state is BOOT, sp=0, fault cleared.
  - Stack contents are don't-care.
  - `pc_next`=RESET_VEC during the reset cycle.
- The first valid fetch is the cycle after BOOT, with `pc_cur`=RESET_VEC.

## Structure
- Package `pc_seq_pkg` holds:
  - the state enum (BOOT, RUN, HALT, FAULT);
  - the default `PC_W`, `STACK_DEPTH` and `RESET_VEC` constants;
  - the next-PC select enum (HOLD, INC, BRANCH, JUMP, CALL, RET, VEC).
- Sub-module `ret_stack`:
  - a parameterised LIFO with push/pop/top/sp ports;
  - full/empty outputs;
  - it makes no overflow decisions (the sequencer gates push/pop).
- Sequencer top contains the FSM, the priority select and the adder.

## Test plan
- **Reset/boot:** assert `rst` for 2 cycles, then release.
  - `pc_next`=0 and `fetch_valid`=0 during reset and BOOT.
  - `pc_cur` then steps 0,1,2,3 with `fetch_valid`=1.
- **Wrap and branch:**
  - `pc_cur`=63 with no controls → `pc_next`=0.
  - `pc_cur`=2, `branch_taken`, `branch_off`=6'b111101 → `pc_next`=63.
  - `pc_cur`=10, `branch_off`=5 → 15.
- **Call/return nesting:**
  - Calls from 5→20, 21→40, 41→50 leave sp=3.
  - Three `ret` cycles then yield 42, 22, 6; sp=0, fault=0.
- **Stack faults:**
  - A 5th call with STACK_DEPTH=4 → `pc_next`=`pc_cur`, fault=1, FAULT state held with `resume` asserted.
  - `rst` clears it.
  - Separately, `ret` with sp=0 → fault=1.
- **Priority and stall:**
  - `stall`+`jump`(`target`=30) at `pc_cur`=7 → `pc_next`=7, sp unchanged.
  - `halt`+`call` → HALT with no push.
  - `ret`+`call` with sp=1 → pop only.
- **Halt/resume and mid-reset:**
  - `halt` at `pc_cur`=12 → `pc_next` holds 12 and `halted`=1 for 5 cycles.
  - `resume` → `pc_cur` goes 12, 13.
  - `rst` asserted while sp=2 in RUN → BOOT, sp=0, next fetch at 0.
